pwm_sample_mixer: RTL

- Produces the 8-bit duty-cycle word that drives the PWM output stage (`dc_in` of the PWM generator). It runs once per PWM period.
- Snapshots NUM_VOICES signed voice samples and their active flags, then sums the active voices one per cycle.
- Applies a 4-bit master volume and clamps or wraps the result, then converts it to offset-binary.
- Holds the result on `dc_out` until the next sample period.

---
 rtl/pwm_sample_mixer_pkg.sv | 14 +
 rtl/pwm_sample_mixer_if.sv | 22 ++
 rtl/pwm_sample_mixer_counter.sv | 22 ++
 rtl/pwm_sample_mixer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/pwm_sample_mixer_pkg.sv
// Shared types and constants for the PWM sample mixer.
package mixer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      SCALE,
      OUTPUT
   } mixer_state_t;

   localparam logic [7:0]  DC_MIDPOINT     = 8'd128;
   localparam int unsigned VOL_UNITY_SHIFT = 2;

endpackage

// File: rtl/pwm_sample_mixer_if.sv
// Voice inputs and duty-cycle outputs of the mixer, bundled for port connection.
interface pwm_sample_mixer_if #(
   parameter int unsigned NUM_VOICES   = 4,
   parameter int unsigned SAMPLE_WIDTH = 8
);
   logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voice_in;
   logic [NUM_VOICES-1:0]              voice_active_in;
   logic [3:0]                         vol_in;
   logic [7:0]                         dc_out;
   logic                               dc_valid_out;
   logic                               overrun_out;

   modport master (
      output voice_in, voice_active_in, vol_in,
      input  dc_out, dc_valid_out, overrun_out
   );

   modport slave (
      input  voice_in, voice_active_in, vol_in,
      output dc_out, dc_valid_out, overrun_out
   );
endinterface

// File: rtl/pwm_sample_mixer_counter.sv
// Free-running modulo counter: counts 0..period_in-1 and wraps to 0.
module counter #(
   parameter int unsigned WIDTH = 9
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [WIDTH-1:0] period_in,
   output logic [WIDTH-1:0] count_out
);
   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = (count_q >= period_in - 1'b1) ? '0 : count_q + 1'b1;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count_out = count_q;
endmodule

// File: rtl/pwm_sample_mixer.sv
// Once per PWM period: snapshot voices, sum active ones, apply volume, emit offset-binary duty word.
// MIXER_SATURATE_EN: clamp the scaled sum to 8-bit signed instead of wrapping.
module pwm_sample_mixer
   import mixer_pkg::*;
#(
   parameter int unsigned NUM_VOICES    = 4,
   parameter int unsigned SAMPLE_WIDTH  = 8,
   parameter int unsigned SAMPLE_PERIOD = 392
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   pwm_sample_mixer_if.slave     bus
);
   localparam int unsigned IDX_W  = $clog2(NUM_VOICES);
   localparam int unsigned ACC_W  = SAMPLE_WIDTH + IDX_W;
   localparam int unsigned PROD_W = ACC_W + 5;
   localparam int unsigned SHIFT  = IDX_W + VOL_UNITY_SHIFT;
   localparam int unsigned CNT_W  = $clog2(SAMPLE_PERIOD + 1);

   logic [CNT_W-1:0] count;
   logic             tick;

   counter #(.WIDTH(CNT_W)) u_period (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .period_in(CNT_W'(SAMPLE_PERIOD)),
      .count_out(count)
   );

   assign tick = (count == CNT_W'(SAMPLE_PERIOD - 1));

   mixer_state_t                       state_q, state_d;
   logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voice_q, voice_d;
   logic [NUM_VOICES-1:0]              active_q, active_d;
   logic [3:0]                         vol_q, vol_d;
   logic signed [ACC_W-1:0]            acc_q, acc_d;
   logic [IDX_W-1:0]                   idx_q, idx_d;
   logic [7:0]                         res_q, res_d;
   logic                               overrun_q, overrun_d;

   logic [SAMPLE_WIDTH-1:0]  sel;
   logic signed [ACC_W-1:0]  addend;
   logic signed [PROD_W-1:0] prod;

   assign sel    = voice_q[idx_q*SAMPLE_WIDTH +: SAMPLE_WIDTH];
   assign addend = active_q[idx_q] ? {{IDX_W{sel[SAMPLE_WIDTH-1]}}, sel} : '0;
   assign prod   = PROD_W'(acc_q) * PROD_W'($signed({1'b0, vol_q}));

`ifdef MIXER_SATURATE_EN
   localparam logic signed [PROD_W-1:0] SAT_HI = 127;
   localparam logic signed [PROD_W-1:0] SAT_LO = -128;
   logic signed [PROD_W-1:0] scaled;
   logic [7:0]               res_scaled;

   assign scaled = prod >>> SHIFT;
   always_comb begin
      if      (scaled > SAT_HI) res_scaled = 8'h7F;
      else if (scaled < SAT_LO) res_scaled = 8'h80;
      else                      res_scaled = 8'(scaled);
   end
`else
   logic [7:0] res_scaled;

   assign res_scaled = 8'(prod >>> SHIFT);
`endif

   always_ff @(posedge clk_in) begin
      if (rst_in) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (tick) state_d = ACCUM;
         ACCUM:   if (idx_q == IDX_W'(NUM_VOICES - 1)) state_d = SCALE;
         SCALE:   state_d = OUTPUT;
         OUTPUT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      voice_d   = voice_q;
      active_d  = active_q;
      vol_d     = vol_q;
      acc_d     = acc_q;
      idx_d     = idx_q;
      res_d     = res_q;
      overrun_d = overrun_q;
      // A tick outside IDLE is dropped; only the sticky flag records it.
      if (tick && (state_q != IDLE)) overrun_d = 1'b1;
      case (state_q)
         IDLE: begin
            if (tick) begin
               voice_d  = bus.voice_in;
               active_d = bus.voice_active_in;
               vol_d    = bus.vol_in;
               acc_d    = '0;
               idx_d    = '0;
            end
         end
         ACCUM: begin
            acc_d = acc_q + addend;
            idx_d = idx_q + 1'b1;
         end
         SCALE:   res_d = res_scaled;
         default: ;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         voice_q   <= '0;
         active_q  <= '0;
         vol_q     <= '0;
         acc_q     <= '0;
         idx_q     <= '0;
         res_q     <= '0;
         overrun_q <= 1'b0;
      end else begin
         voice_q   <= voice_d;
         active_q  <= active_d;
         vol_q     <= vol_d;
         acc_q     <= acc_d;
         idx_q     <= idx_d;
         res_q     <= res_d;
         overrun_q <= overrun_d;
      end
   end

   // res_q holds the signed result; flipping the sign bit adds the midpoint.
   always_comb begin
      bus.dc_out       = {~res_q[7], res_q[6:0]};
      bus.dc_valid_out = (state_q == OUTPUT);
      bus.overrun_out  = overrun_q;
   end

endmodule
